// File: rtl/jzjpcc_memory_stage_ext.sv
// Memory stage: data-port handshake, byte-lane alignment, load formatting, writeback register.
// Optional JZJPCC_MISALIGN_TRAP_EN: misaligned accesses trap instead of being rounded down.
module jzjpcc_memory_stage_ext #(
    parameter int RAM_A_WIDTH    = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   valid_memory,
    input  logic                   memRead_memory,
    input  logic                   memWrite_memory,
    input  logic [2:0]             funct3_memory,
    input  logic [31:0]            aluResult_memory,
    input  logic [31:0]            storeData_memory,
    input  logic [4:0]             rdAddr_memory,
    input  logic                   rdWriteEnable_memory,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [RAM_A_WIDTH-3:0] mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_byteMask,
    input  logic                   mem_ready,
    input  logic [31:0]            mem_rdata,
    output logic                   stall_memory,
    output logic                   bus_error,
`ifdef JZJPCC_MISALIGN_TRAP_EN
    output logic                   misalign_trap,
`endif
    output logic                   valid_writeback,
    output logic [4:0]             rdAddr_writeback,
    output logic                   rdWriteEnable_writeback,
    output logic [31:0]            rdData_writeback
);

    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_n;
    logic        w_timeout;

    logic        r_valid_wb;
    logic [4:0]  r_rd_wb;
    logic        r_we_wb;
    logic [31:0] r_data_wb;

    logic [1:0]  w_off;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_access;
    logic        w_req;
    logic        w_trap;
    logic        w_bubble;
    logic        w_sext;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load;
    logic [31:0] w_wdata;
    logic [3:0]  w_mask;
    logic        w_unused;

    // Upper address bits are outside the data memory and intentionally dropped
    assign w_unused  = ^aluResult_memory[31:RAM_A_WIDTH];

    assign w_off     = aluResult_memory[1:0];
    assign w_is_byte = (funct3_memory[1:0] == 2'b00);
    assign w_is_half = (funct3_memory[1:0] == 2'b01);
    assign w_access  = valid_memory & (memRead_memory | memWrite_memory);

`ifdef JZJPCC_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_trap;

    assign w_misalign    = (w_is_half & w_off[0])
                         | (funct3_memory[1] & (|w_off));
    assign w_req         = w_access & ~w_misalign;
    assign w_trap        = w_access & w_misalign;
    assign misalign_trap = r_trap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_trap;
        end
    end
`else
    assign w_req  = w_access;
    assign w_trap = 1'b0;
`endif

    assign mem_req      = w_req;
    assign mem_we       = memWrite_memory;
    assign mem_addr     = aluResult_memory[RAM_A_WIDTH-1:2];
    assign mem_wdata    = w_wdata;
    assign mem_byteMask = w_mask;

    always_comb begin
        w_wdata = storeData_memory;
        w_mask  = 4'hF;
        if (memWrite_memory) begin
            unique case (1'b1)
                w_is_byte: begin
                    w_wdata = {4{storeData_memory[7:0]}};
                    w_mask  = 4'b0001 << w_off;
                end
                w_is_half: begin
                    w_wdata = {2{storeData_memory[15:0]}};
                    w_mask  = w_off[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_wdata = storeData_memory;
                    w_mask  = 4'hF;
                end
            endcase
        end
    end

    always_comb begin
        w_lane_b = mem_rdata[7:0];
        unique case (w_off)
            2'd0:    w_lane_b = mem_rdata[7:0];
            2'd1:    w_lane_b = mem_rdata[15:8];
            2'd2:    w_lane_b = mem_rdata[23:16];
            default: w_lane_b = mem_rdata[31:24];
        endcase
    end

    assign w_lane_h = w_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign w_sext   = ~funct3_memory[2];

    // funct3 codes 3, 6 and 7 fall into the word branch
    always_comb begin
        w_load = mem_rdata;
        unique case (1'b1)
            w_is_byte: w_load = {{24{w_sext & w_lane_b[7]}}, w_lane_b};
            w_is_half: w_load = {{16{w_sext & w_lane_h[15]}}, w_lane_h};
            default:   w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_n    = r_state;
        w_wait_cnt_n = r_wait_cnt;
        w_timeout    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req & ~mem_ready) begin
                    w_state_n    = S_WAIT;
                    w_wait_cnt_n = 8'd1;
                end
            end
            S_WAIT: begin
                if (mem_ready | ~w_req) begin
                    w_state_n    = S_IDLE;
                    w_wait_cnt_n = 8'd0;
                end else if (r_wait_cnt == TIMEOUT) begin
                    w_timeout    = 1'b1;
                    w_state_n    = S_IDLE;
                    w_wait_cnt_n = 8'd0;
                end else begin
                    w_wait_cnt_n = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_n    = S_IDLE;
                w_wait_cnt_n = 8'd0;
            end
        endcase
    end

    assign stall_memory = w_req & ~mem_ready & ~w_timeout;
    assign bus_error    = w_timeout;
    // A stalled, abandoned or trapped instruction leaves a bubble behind it
    assign w_bubble     = stall_memory | w_timeout | w_trap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_valid_wb <= 1'b0;
            r_rd_wb    <= 5'd0;
            r_we_wb    <= 1'b0;
            r_data_wb  <= 32'd0;
        end else begin
            r_state    <= w_state_n;
            r_wait_cnt <= w_wait_cnt_n;
            if (w_bubble) begin
                r_valid_wb <= 1'b0;
                r_we_wb    <= 1'b0;
            end else begin
                r_valid_wb <= valid_memory;
                r_rd_wb    <= rdAddr_memory;
                r_we_wb    <= valid_memory & rdWriteEnable_memory;
                r_data_wb  <= memRead_memory ? w_load : aluResult_memory;
            end
        end
    end

    assign valid_writeback         = r_valid_wb;
    assign rdAddr_writeback        = r_rd_wb;
    assign rdWriteEnable_writeback = r_we_wb;
    assign rdData_writeback        = r_data_wb;

endmodule

// File: doc/jzjpcc_memory_stage_ext.md
Name: jzjpcc_memory_stage_ext

Overview:
- Memory stage of the pipelined core, between the execute/memory pipeline register and writeback.
- Drives a word-organised data memory port with a valid/ready handshake, so multi-cycle memories stall the pipeline.
- Performs byte-lane store alignment and load extraction/sign-extension for RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Selects the rd writeback data (ALU result or formatted load) and registers it into writeback, with a bus timeout.

Parameters:
- RAM_A_WIDTH, 12, data memory byte-address width; word address is [RAM_A_WIDTH-1:2].
- TIMEOUT_CYCLES, 255, maximum stall cycles before a request is abandoned (range 1..255).

Ports:
- clock  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_memory  in  1  instruction in memory stage is valid.
- memRead_memory  in  1  instruction is a load.
- memWrite_memory  in  1  instruction is a store (never set together with memRead_memory).
- funct3_memory  in  3  RV32I width/sign code.
- aluResult_memory  in  32  ALU result; byte address for loads and stores.
- storeData_memory  in  32  rs2 value for stores.
- rdAddr_memory  in  5  destination register.
- rdWriteEnable_memory  in  1  instruction writes rd.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write.
- mem_addr  out  RAM_A_WIDTH-2  word address.
- mem_wdata  out  32  lane-aligned write data.
- mem_byteMask  out  4  byte enables.
- mem_ready  in  1  memory accepts write / returns read data this cycle.
- mem_rdata  in  32  read word, valid when mem_ready.
- stall_memory  out  1  to the hazard unit; freezes stages up to and including memory.
- bus_error  out  1  one-cycle pulse on timeout.
- valid_writeback  out  1  registered valid.
- rdAddr_writeback  out  5  registered rd.
- rdWriteEnable_writeback  out  1  registered write enable.
- rdData_writeback  out  32  registered rd data.

Behaviour:
- Access condition: `access` = valid_memory & (memRead_memory | memWrite_memory).
- Request outputs (combinational): mem_req = access. mem_we = memWrite_memory. mem_addr = aluResult_memory[RAM_A_WIDTH-1:2]; address bits above RAM_A_WIDTH-1 are ignored.
- Store alignment, using offset = aluResult_memory[1:0]:
  - SB: mem_wdata = byte replicated x4; mask = 1 << offset.
  - SH: mem_wdata = half replicated x2; mask = 0011 << offset[1]*2.
  - SW: mem_wdata = storeData_memory; mask = 1111.
  - Loads: mask = 1111.
- Stall: stall_memory = mem_req & ~mem_ready.
  - Upstream holds every memory-stage input stable while stalled.
  - A zero-wait memory (ready in the same cycle) produces no stall.
- FSM states:
  - IDLE: on a stall, go to WAIT with wait_cnt = 1.
  - WAIT: on mem_ready, go to IDLE. Otherwise, if wait_cnt == TIMEOUT_CYCLES, pulse bus_error, force stall_memory low that cycle, and go to IDLE. Otherwise increment wait_cnt.
  - wait_cnt is 8 bits and is cleared on every return to IDLE.
- Timeout retirement: the timed-out instruction retires as a bubble (valid_writeback = 0, rdWriteEnable_writeback = 0).
- Load format: select a lane by offset; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Unknown funct3 is treated as LW.
- Writeback register update, each rising clock when not stalled:
  - valid_writeback <= valid_memory.
  - rdAddr_writeback <= rdAddr_memory.
  - rdWriteEnable_writeback <= valid_memory & rdWriteEnable_memory.
  - rdData_writeback <= formatted load if memRead_memory, else aluResult_memory.
- Writeback register update while stalled: load a bubble (valid_writeback = 0, rdWriteEnable_writeback = 0; rdAddr and rdData hold).
- Reset (asynchronous, reset_n low), taking effect immediately including mid-wait:
  - FSM -> IDLE, wait_cnt = 0.
  - valid_writeback = 0, rdWriteEnable_writeback = 0, rdAddr_writeback = 0, rdData_writeback = 0, bus_error = 0.
  - The combinational outputs follow their inputs; a pending request is dropped.

Optional Feature:
- Macro: JZJPCC_MISALIGN_TRAP_EN.
- Misaligned access: halfword with offset[0] = 1, or word with offset != 0.
- Without the macro:
  - Misaligned accesses proceed as if offset were rounded down to natural alignment.
  - The misalign_trap port does not exist.
- With the macro:
  - An extra output, misalign_trap (1 bit), is registered and reset to 0.
  - For a misaligned access, mem_req = 0 and no stall occurs.
  - misalign_trap pulses for one cycle alongside a bubble in writeback (rdWriteEnable_writeback = 0).

Test Plan:
- Zero-wait LB, addr 0x003, mem_ready = 1, rdata 0x80FF_1234 -> no stall; next cycle rdData_writeback = 0xFFFF_FF80, rdWriteEnable_writeback = 1.
- SH, addr 0x006, storeData 0x0000_ABCD -> mem_wdata 0xABCD_ABCD, mem_byteMask 1100, mem_we = 1, mem_addr = 0x001.
- LW with mem_ready low 3 cycles -> stall_memory high for exactly 3 cycles, 3 bubbles in writeback; then rdData_writeback = mem_rdata.
- TIMEOUT_CYCLES = 4, mem_ready never asserted -> bus_error pulses once at the 4th wait cycle, stall drops, writeback bubble, FSM back to IDLE.
- reset_n low during WAIT -> all registered outputs 0 immediately; after release a new LHU at addr 0x002 with rdata 0x8001_0000 returns 0x0000_8001.
- With JZJPCC_MISALIGN_TRAP_EN, LW at 0x001 -> mem_req = 0, misalign_trap = 1 for one cycle, rdWriteEnable_writeback = 0; without the macro the same access reads word 0.
